// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM states and the byte-lane helpers used for stores and load extension.
package dmem_pkg;

   localparam int          F3_WIDTH = 3;
   localparam logic [2:0]  F3_B     = 3'b000;
   localparam logic [2:0]  F3_H     = 3'b001;
   localparam logic [2:0]  F3_W     = 3'b010;
   localparam logic [2:0]  F3_BU    = 3'b100;
   localparam logic [2:0]  F3_HU    = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return {off[1], 1'b0};
         F3_W:        return 2'b00;
         default:     return off;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: return 4'b0001 << off;
         F3_H, F3_HU: return 4'b0011 << off;
         F3_W:        return 4'b1111;
         default:     return 4'b0000;
      endcase
   endfunction

   // Replicate the right-aligned store data so every lane the enable picks sees it.
   function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
      case (f3)
         F3_B, F3_BU: return {4{wdata[7:0]}};
         F3_H, F3_HU: return {2{wdata[15:0]}};
         default:     return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_BU:   return {24'h000000, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_HU:   return {16'h0000, sh[15:0]};
         F3_W:    return word;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word store with per-byte write enables; the read
// port registers the addressed word whenever the port is enabled.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic [3:0]        we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder (IDLE -> WAIT -> RESP). Defining
// DMEM_MISALIGN_TRAP_EN makes misaligned H/W accesses fault instead of aligning down.
import dmem_pkg::*;

module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        busy,
   output logic        mem_err
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              issued_q;
   logic [ADDR_W-1:0] wordIdx_q;
   logic [1:0]        byteOff_q;
   logic [2:0]        func3_q;
   logic [31:0]       wLane_q;
   logic [3:0]        be_q;
   logic              err_q;
   logic              store_q;
   logic [31:0]       rdata_q;
   logic [31:0]       rdata_d;
   logic              mem_ready_q;
   logic              mem_err_q;
   logic              busy_q;

   logic              outOfRange;
   logic              alignErr;
   logic              reqErr;
   logic [1:0]        reqOff;
   logic              arrEn;
   logic [3:0]        arrWe;
   logic [31:0]       arrRdata;

   assign outOfRange = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign alignErr = f3_misaligned(func3, addr[1:0]);
   assign reqOff   = addr[1:0];
`else
   assign alignErr = 1'b0;
   assign reqOff   = f3_align(func3, addr[1:0]);
`endif

   assign reqErr = (mem_read && mem_write) || !f3_legal(func3) || outOfRange || alignErr;

   // The array is touched exactly once per request, in the last WAIT cycle; a
   // reset before then leaves state_q in IDLE so an aborted store never writes.
   assign arrEn = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !issued_q;
   assign arrWe = arrEn ? be_q : 4'b0000;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_array (
      .clk_i  (clk),
      .en_i   (arrEn),
      .we_i   (arrWe),
      .addr_i (wordIdx_q),
      .wdata_i(wLane_q),
      .rdata_o(arrRdata)
   );

   always_comb begin
      rdata_d = 32'h0000_0000;
      if (!err_q && !store_q) begin
         rdata_d = load_extend(func3_q, byteOff_q, arrRdata);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         issued_q    <= 1'b0;
         wordIdx_q   <= '0;
         byteOff_q   <= 2'b00;
         func3_q     <= 3'b000;
         wLane_q     <= 32'h0000_0000;
         be_q        <= 4'b0000;
         err_q       <= 1'b0;
         store_q     <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mem_read || mem_write) begin
                  state_q   <= ST_WAIT;
                  busy_q    <= 1'b1;
                  cnt_q     <= 4'(LATENCY - 1);
                  issued_q  <= 1'b0;
                  wordIdx_q <= addr[ADDR_W+1:2];
                  byteOff_q <= reqOff;
                  func3_q   <= func3;
                  wLane_q   <= lane_data(func3, wdata);
                  be_q      <= (reqErr || mem_read) ? 4'b0000 : byte_en(func3, reqOff);
                  err_q     <= reqErr;
                  store_q   <= mem_write && !mem_read;
               end
            end
            ST_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else if (!issued_q) begin
                  issued_q <= 1'b1;
               end else begin
                  state_q     <= ST_RESP;
                  mem_ready_q <= 1'b1;
                  mem_err_q   <= err_q;
                  rdata_q     <= rdata_d;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata     = rdata_q;
   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, randomized
// traffic against a byte-level memory model, and a reset-abort sequence.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 3;
   localparam int MDL_BYTES = 64;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        mem_ready;
   logic        busy;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] mdl [MDL_BYTES];

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .func3    (func3),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .mem_ready(mem_ready),
      .busy     (busy),
      .mem_err  (mem_err)
   );

   always #5 clk = ~clk;

   function automatic void addVec(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] ed, input logic ee);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.expData = ed; v.expErr = ee;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string what, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d]: got 0x%08h, required 0x%08h", what, idx, act, exp);
      end
   endtask

   // Reference behaviour from the access rules: size from func3, byte-addressed memory.
   task automatic modelAccess(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] expData, output logic expErr);
      int size;
      int base;
      logic [31:0] val;
      logic legal;
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      expErr = (rd && wr) || !legal || ((a / 4) >= 32'(DEPTH));
      if (TRAP && legal && ((a % 32'(size)) != 0)) expErr = 1'b1;
      expData = 32'h0;
      if (expErr) return;
      base = int'(a - (a % 32'(size)));
      if (wr) begin
         for (int i = 0; i < size; i++) mdl[base+i] = wd[8*i +: 8];
      end else begin
         val = 32'h0;
         for (int i = 0; i < size; i++) val = val | ({24'h0, mdl[base+i]} << (8*i));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
         expData = val;
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] expData, input logic expErr, input int idx);
      int cycles;
      @(negedge clk);
      mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
      @(posedge clk); #1;
      checkOutput("busyAccept", idx, {31'h0, busy}, 32'h1);
      cycles = 0;
      while (!mem_ready && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("latency", idx, 32'(cycles), 32'(LAT + 1));
      checkOutput("rdata", idx, rdata, expData);
      checkOutput("memErr", idx, {31'h0, mem_err}, {31'h0, expErr});
      checkOutput("busyResp", idx, {31'h0, busy}, 32'h1);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1;
      checkOutput("readyPulse", idx, {31'h0, mem_ready}, 32'h0);
      checkOutput("busyIdle", idx, {31'h0, busy}, 32'h0);
      checkOutput("rdataHold", idx, rdata, expData);
   endtask

   initial begin
      logic        rd, wr, ee, sawReady;
      logic [2:0]  f3;
      logic [31:0] a, wd, ed;
      int          sel;

      rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstRdata", 0, rdata, 32'h0);
      checkOutput("rstReady", 0, {31'h0, mem_ready}, 32'h0);
      checkOutput("rstBusy", 0, {31'h0, busy}, 32'h0);
      checkOutput("rstErr", 0, {31'h0, mem_err}, 32'h0);
      rst_n = 1'b1;

      addVec(0, 1, 3'b010, 32'h00,  32'hCAFEF00D, 32'h0,        0);
      addVec(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
      addVec(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
      addVec(1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
      addVec(1, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0);
      addVec(1, 0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0);
      addVec(0, 1, 3'b000, 32'h11,  32'h00000055, 32'h0,        0);
      addVec(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
      addVec(0, 1, 3'b010, 32'h400, 32'h12345678, 32'h0,        1);
      addVec(1, 0, 3'b010, 32'h00,  32'h0,        32'hCAFEF00D, 0);
      addVec(0, 1, 3'b010, 32'h410, 32'h12345678, 32'h0,        1);
      addVec(1, 1, 3'b010, 32'h10,  32'h11111111, 32'h0,        1);
      addVec(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
      addVec(1, 0, 3'b010, 32'h12,  32'h0,        TRAP ? 32'h0 : 32'hDEAD55EF, TRAP);
      addVec(1, 0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
      addVec(0, 1, 3'b110, 32'h10,  32'hFFFFFFFF, 32'h0,        1);
      addVec(1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0);
      addVec(1, 0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 0);
      addVec(1, 0, 3'b001, 32'h10,  32'h0,        32'h000055EF, 0);
      addVec(0, 1, 3'b001, 32'h13,  32'hBEEF1234, 32'h0,        TRAP);
      addVec(1, 0, 3'b010, 32'h10,  32'h0,        TRAP ? 32'hDEAD55EF : 32'h123455EF, 0);
      addVec(1, 0, 3'b010, 32'h01,  32'h0,        TRAP ? 32'h0 : 32'hCAFEF00D, TRAP);
      addVec(1, 0, 3'b100, 32'h01,  32'h0,        32'h000000F0, 0);
      addVec(1, 0, 3'b000, 32'h02,  32'h0,        32'hFFFFFFFE, 0);
      addVec(1, 0, 3'b101, 32'h03,  32'h0,        TRAP ? 32'h0 : 32'h0000CAFE, TRAP);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].expData, vecs[i].expErr, i);
      end

      for (int w = 0; w < MDL_BYTES / 4; w++) begin
         wd = $urandom();
         modelAccess(1'b0, 1'b1, 3'b010, 32'(w * 4), wd, ed, ee);
         applyStimulus(1'b0, 1'b1, 3'b010, 32'(w * 4), wd, ed, ee, 50 + w);
      end

      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 19);
         rd = (sel < 10) || (sel == 19);
         wr = (sel >= 10);
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, MDL_BYTES - 1));
         if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
         wd = $urandom();
         modelAccess(rd, wr, f3, a, wd, ed, ee);
         applyStimulus(rd, wr, f3, a, wd, ed, ee, 100 + i);
      end

      // Store aborted by reset while waiting must leave the old word in place.
      modelAccess(1'b0, 1'b1, 3'b010, 32'h10, 32'hA5A55A5A, ed, ee);
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hA5A55A5A, ed, ee, 400);
      modelAccess(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ed, ee);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ed, ee, 401);

      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010; addr = 32'h10; wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      checkOutput("abortBusy", 402, {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abortBusyRst", 402, {31'h0, busy}, 32'h0);
      checkOutput("abortReadyRst", 402, {31'h0, mem_ready}, 32'h0);
      checkOutput("abortRdataRst", 402, rdata, 32'h0);
      checkOutput("abortErrRst", 402, {31'h0, mem_err}, 32'h0);
      mem_write = 1'b0;
      sawReady = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (mem_ready) sawReady = 1'b1;
      end
      checkOutput("abortNoReady", 402, {31'h0, sawReady}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      modelAccess(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ed, ee);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ed, ee, 403);
      checkOutput("abortOldData", 403, ed, 32'hA5A55A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of data storage; it SHALL be a power of two.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and response; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port mem_read, input, 1, meaning a load request from control.
REQ-006 The block SHALL have port mem_write, input, 1, meaning a store request from control.
REQ-007 The block SHALL have port func3, input, 3, meaning the load/store size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port addr, input, 32, meaning the byte address from the ALU.
REQ-009 The block SHALL have port wdata, input, 32, meaning the store data, right-aligned.
REQ-010 The block SHALL have port rdata, output, 32, meaning the load result after extension.
REQ-011 The block SHALL have port mem_ready, output, 1, meaning a one-cycle response pulse.
REQ-012 The block SHALL have port busy, output, 1, meaning a request is in flight.
REQ-013 The block SHALL have port mem_err, output, 1, meaning the completed request faulted; it is valid only with mem_ready.

Function
REQ-014 The block SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-015 In IDLE, at a clock edge with mem_read|mem_write=1, the block SHALL capture addr, wdata and func3, SHALL load the wait counter with LATENCY-1, and SHALL enter WAIT.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL perform the array access and enter RESP.
REQ-017 In RESP, mem_ready SHALL be 1 for exactly one cycle, rdata and mem_err SHALL be valid, and the next state SHALL be IDLE.
REQ-018 A request accepted at edge N SHALL produce mem_ready high during the cycle after edge N+LATENCY+1.
REQ-019 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-020 mem_read and mem_write SHALL be ignored outside IDLE; the core holds them stable until mem_ready.
REQ-021 If mem_read=1 and mem_write=1 together, the block SHALL accept the request, SHALL not modify the array, SHALL return rdata=0, and SHALL return mem_err=1.
REQ-022 Loads SHALL sign-extend for B/H, zero-extend for BU/HU, and pass W unchanged.
REQ-023 Byte lanes SHALL be selected by addr[1:0].
REQ-024 Stores SHALL write only the enabled byte lanes: SB one lane, SH two lanes, SW four lanes.
REQ-025 On a store response, rdata SHALL be 0.
REQ-026 A func3 value outside the legal set, or a word index addr[31:2] >= DEPTH_WORDS, SHALL cause mem_err=1, rdata=0 and no write.
REQ-027 Outside RESP, rdata SHALL hold its last value.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, mem_ready=0, mem_err=0, busy=0 and rdata=0, including mid-request; an aborted store SHALL not write.
REQ-029 The array contents SHALL not be reset.

Configuration
REQ-030 When DMEM_MISALIGN_TRAP_EN is defined, an H access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL give mem_err=1, rdata=0 and no write.
REQ-031 When DMEM_MISALIGN_TRAP_EN is undefined, such accesses SHALL silently align the address down (H: addr[0] forced to 0; W: addr[1:0] forced to 00) and complete without error.

Structure
REQ-032 Package dmem_pkg SHALL hold the func3 width/sign constants, the FSM state enum, and the byte-enable function.
REQ-033 Storage SHALL be a sub-module dmem_array: a single-port synchronous word array with a 4-bit byte write enable.

Verification
REQ-034 Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> LW response rdata=0xDEADBEEF, mem_err=0, each mem_ready at N+LATENCY+1.
REQ-035 LB addr=0x13 -> rdata=0xFFFFFFDE; LBU addr=0x13 -> rdata=0x000000DE; LHU addr=0x12 -> rdata=0x0000DEAD.
REQ-036 SB addr=0x11 wdata=0x55, then LW addr=0x10 -> rdata=0xDEAD55EF.
REQ-037 Store to addr=DEPTH_WORDS*4 -> mem_err=1 and memory unchanged; mem_read=mem_write=1 -> mem_err=1 and rdata=0.
REQ-038 LW addr=0x12 -> mem_err=1 with DMEM_MISALIGN_TRAP_EN defined; rdata=0xDEAD55EF with it undefined.
REQ-039 SW pulled into reset during WAIT -> busy=0 immediately, no mem_ready, and a following LW returns the old data.
